// File: rtl/pipeline_sequencer.sv
// Contour pipeline sequencer: steps sobel -> erosion -> one_edge -> color_contour and owns the shared memory ports.
// Optional per-stage watchdog enabled by defining STAGE_TIMEOUT_EN.
module pipeline_sequencer #(
  parameter int ADDR_W  = 19,
  parameter int EDGE_W  = 3,
  parameter int TIMEOUT = 2000000
) (
  input  logic              clk_25mhz,
  input  logic              rst,
  input  logic              run,
  input  logic              abort,
  input  logic [1:0]        depth,
  output logic              sobel_start,
  output logic              erosion_start,
  output logic              edge_start,
  output logic              color_start,
  input  logic              sobel_done,
  input  logic              erosion_done,
  input  logic              one_edge_done,
  input  logic              color_done,
  input  logic [ADDR_W-1:0] st_addr_a [4],
  input  logic [EDGE_W-1:0] st_din_a [4],
  input  logic [ADDR_W-1:0] st_addr_b [1:3],
  input  logic [ADDR_W-1:0] sobel_rgb_addr,
  input  logic [ADDR_W-1:0] vga_addr,
  output logic [ADDR_W-1:0] edge_bram_addr,
  output logic [EDGE_W-1:0] edge_bram_din,
  output logic              edge_bram_we,
  output logic [ADDR_W-1:0] edge_bram_addrb,
  output logic [ADDR_W-1:0] memory_read_addr,
  output logic [2:0]        stage,
  output logic              busy,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SOBEL    = 3'd1,
    ST_EROSION  = 3'd2,
    ST_ONE_EDGE = 3'd3,
    ST_COLOR    = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  depth_q, depth_d;
  logic [3:0]  done_vec, done_q, done_rise;
  logic        entry_q;
  logic        in_stage;
  logic [1:0]  cur_idx;
  logic [1:0]  last_idx;
  logic        timeout_hit;
  logic [3:0]  starts;

  assign done_vec  = {color_done, one_edge_done, erosion_done, sobel_done};
  assign done_rise = done_vec & ~done_q;
  assign in_stage  = (state_q == ST_SOBEL) || (state_q == ST_EROSION) ||
                     (state_q == ST_ONE_EDGE) || (state_q == ST_COLOR);
  assign last_idx  = (depth_q == 2'd0) ? 2'd1 : depth_q;

  always_comb begin
    cur_idx = 2'd0;
    case (state_q)
      ST_EROSION:  cur_idx = 2'd1;
      ST_ONE_EDGE: cur_idx = 2'd2;
      ST_COLOR:    cur_idx = 2'd3;
      default:     cur_idx = 2'd0;
    endcase
  end

`ifdef STAGE_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;

  // Counter restarts on every state change so each stage gets its own full budget
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (in_stage) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end

  assign timeout_hit = in_stage && (tmo_cnt_q == 32'(TIMEOUT - 1));
  assign error       = (state_q == ST_ERROR);
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_25mhz or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      depth_q <= 2'd0;
      done_q  <= 4'd0;
      entry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      done_q  <= done_vec;
      entry_q <= (state_d != state_q);
    end
  end

  // Next state: abort wins, then the current stage's done edge, then the watchdog
  always_comb begin
    state_d = state_q;
    depth_d = depth_q;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (run) begin
            state_d = ST_SOBEL;
            depth_d = depth;
          end
        end
        ST_SOBEL, ST_EROSION, ST_ONE_EDGE, ST_COLOR: begin
          if (!entry_q && done_rise[cur_idx]) begin
            state_d = (cur_idx == last_idx) ? ST_DONE : state_t'(state_q + 3'd1);
          end else if (timeout_hit) begin
            state_d = ST_ERROR;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Outputs and port ownership
  always_comb begin
    starts           = 4'b0000;
    edge_bram_addr   = '0;
    edge_bram_din    = '0;
    edge_bram_we     = 1'b0;
    edge_bram_addrb  = vga_addr;
    memory_read_addr = vga_addr;
    case (state_q)
      ST_SOBEL: begin
        starts           = 4'b0001;
        edge_bram_addr   = st_addr_a[0];
        edge_bram_din    = st_din_a[0];
        edge_bram_we     = 1'b1;
        memory_read_addr = sobel_rgb_addr;
      end
      ST_EROSION: begin
        starts          = 4'b0011;
        edge_bram_addr  = st_addr_a[1];
        edge_bram_din   = st_din_a[1];
        edge_bram_we    = 1'b1;
        edge_bram_addrb = st_addr_b[1];
      end
      ST_ONE_EDGE: begin
        starts          = 4'b0111;
        edge_bram_addr  = st_addr_a[2];
        edge_bram_din   = st_din_a[2];
        edge_bram_we    = 1'b1;
        edge_bram_addrb = st_addr_b[2];
      end
      ST_COLOR: begin
        starts          = 4'b1111;
        edge_bram_addr  = st_addr_a[3];
        edge_bram_din   = st_din_a[3];
        edge_bram_we    = 1'b1;
        edge_bram_addrb = st_addr_b[3];
      end
      ST_DONE: begin
        case (last_idx)
          2'd2:    starts = 4'b0111;
          2'd3:    starts = 4'b1111;
          default: starts = 4'b0011;
        endcase
      end
      default: starts = 4'b0000;
    endcase
  end

  assign sobel_start   = starts[0];
  assign erosion_start = starts[1];
  assign edge_start    = starts[2];
  assign color_start   = starts[3];
  assign stage         = state_q;
  assign busy          = in_stage;
  assign done          = (state_q == ST_DONE);

endmodule
